multiplicador_seq: RTL and testbench
====================================

// Module: multiplicador_seq
// PURPOSE
//   Sequential shift-add unsigned multiplier; producer side of the ALU's multiply path.
//   Takes two WIDTH-bit operands on a start pulse and computes the full 2*WIDTH product,
//   one multiplier bit per clock.
//   Drives the ALU's s_multi (low WIDTH bits of product) and ov_mult (product does not fit in WIDTH bits).
//   Handshake busy/done toward the top-level controller; results held stable between operations.
// PARAMETERS
//   WIDTH   8   operand and result width (bits); product register is 2*WIDTH
// PORTS
//   clk      in   1      system clock, all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; sampled only in IDLE
//   A        in   WIDTH  multiplicand, captured on accepted start
//   B        in   WIDTH  multiplier, captured on accepted start
//   s_multi  out  WIDTH  product[WIDTH-1:0], registered
//   ov_mult  out  1      1 when product[2*WIDTH-1:WIDTH] != 0, registered
//   busy     out  1      1 while in CALC or DONE
//   done     out  1      one-cycle pulse: s_multi/ov_mult updated this cycle
// BEHAVIOUR
//   Reset: state=IDLE; s_multi=0, ov_mult=0, busy=0, done=0; internal regs cleared.
//   Reset wins over every other event, including mid-CALC: operation discarded, no done.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: start=1 at edge t0 -> latch mcand={WIDTH'b0,A}, mplier=B, acc=0, count=0; go CALC.
//     start=0 -> stay IDLE; outputs hold last result.
//   CALC: each edge: if mplier[0] acc<=acc+mcand; mcand<=mcand<<1; mplier<=mplier>>1;
//     count<=count+1. Fixed WIDTH iterations, no early exit on zero operands.
//     After the WIDTH-th iteration (edge t0+WIDTH) go DONE.
//   DONE: outputs computed from final acc; registered at edge t0+WIDTH+1:
//     s_multi<=acc[WIDTH-1:0], ov_mult<=|acc[2*WIDTH-1:WIDTH], done<=1 for exactly that cycle;
//     state -> IDLE on same edge.
//   Latency: done high in cycle starting WIDTH+1 edges after the edge that sampled start (9 for W=8).
//   start while busy=1 ignored (not queued). A/B changes after capture have no effect.
//   start high on the cycle done is high (state IDLE): accepted -> back-to-back op, busy reasserts next edge.
//   s_multi/ov_mult change only on a done cycle or reset; stable otherwise.
//   Accumulator width 2*WIDTH: no internal overflow possible (max (2^W-1)^2).
//   count is ceil(log2(WIDTH+1)) bits; no wrap inside an operation.
// TESTING
//   1) rst high 2 cycles -> s_multi=0, ov_mult=0, busy=0, done=0; rst mid-CALC -> IDLE, no done pulse.
//   2) A=15,B=17 start -> done exactly 9 cycles later, s_multi=0xFF, ov_mult=0, single-cycle done.
//   3) A=16,B=16 -> s_multi=0x00, ov_mult=1; A=255,B=255 -> s_multi=0x01, ov_mult=1 (0xFE01).
//   4) A=0,B=200 and A=200,B=0 -> s_multi=0, ov_mult=0, latency still 9.
//   5) start pulsed again at cycles 3 and 5 of busy with other A/B -> ignored, result of first op only.
//   6) start held high continuously, A=3,B=5 then A=7,B=9 -> done every 10 cycles, outputs 15 then 63.

Source files
------------

// File: rtl/multiplicador_seq.sv
// Sequential shift-add unsigned multiplier for the ALU multiply path.
// One multiplier bit is consumed per clock; the full 2*WIDTH product is
// accumulated. The outputs carry the low half of the product and a flag
// that is set when the high half is non-zero. The outputs change only on
// the done cycle or on reset.
module multiplicador_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] s_multi,
  output logic             ov_mult,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // The last iteration is the one that runs while count still reads WIDTH-1.
  logic last_iter;
  assign last_iter = (count == CW'(WIDTH - 1));

  // busy is derived from the registered state, so it is glitch-free.
  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture the operands, run the shift-add iterations, then publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      s_multi <= '0;
      ov_mult <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            count  <= '0;
          end
        end
        S_CALC: begin
          // Fixed WIDTH passes and no early exit, so the latency does not depend on the data.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        S_DONE: begin
          s_multi <= acc[WIDTH-1:0];
          ov_mult <= |acc[2*WIDTH-1:WIDTH];
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: a table of directed vectors, random operands
// checked against the arithmetic product, and hand-written multi-cycle
// sequences covering ignored start, continuous start, and reset mid-operation.
module tb_multiplicador_seq;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] s_multi;
  logic         ov_mult, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .s_multi (s_multi),
    .ov_mult (ov_mult),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic         ov;
    bit           poke;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation and returns the number of edges from the accepting
  // edge to the edge that raised done. With poke set, start is pulsed again
  // mid-operation with different operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output int lat);
    logic [W-1:0] prev_lo;
    logic         prev_ov;
    @(negedge clk);
    prev_lo = s_multi;
    prev_ov = ov_mult;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    lat = 0;
    while (lat < 30) begin
      start = poke && (lat == 2 || lat == 4);
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat == 4) begin
        chk("hold_lo_midop", {24'b0, s_multi}, {24'b0, prev_lo});
        chk("hold_ov_midop", {31'b0, ov_mult}, {31'b0, prev_ov});
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat,
                              input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = (2*W)'(a) * (2*W)'(b);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_lo"}, {24'b0, s_multi}, {24'b0, prod[W-1:0]});
    chk({tag, "_ov"}, {31'b0, ov_mult}, {31'b0, (prod[2*W-1:W] != 0)});
    chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    int seen;

    tbl[0] = '{a: 8'd15,  b: 8'd17,  lo: 8'hFF, ov: 1'b0, poke: 1'b0};
    tbl[1] = '{a: 8'd16,  b: 8'd16,  lo: 8'h00, ov: 1'b1, poke: 1'b0};
    tbl[2] = '{a: 8'd255, b: 8'd255, lo: 8'h01, ov: 1'b1, poke: 1'b0};
    tbl[3] = '{a: 8'd0,   b: 8'd200, lo: 8'h00, ov: 1'b0, poke: 1'b0};
    tbl[4] = '{a: 8'd200, b: 8'd0,   lo: 8'h00, ov: 1'b0, poke: 1'b0};
    tbl[5] = '{a: 8'd12,  b: 8'd11,  lo: 8'h84, ov: 1'b0, poke: 1'b1};
    tbl[6] = '{a: 8'd1,   b: 8'd255, lo: 8'hFF, ov: 1'b0, poke: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lo",   {24'b0, s_multi}, 32'd0);
    chk("rst_ov",   {31'b0, ov_mult}, 32'd0);
    chk("rst_busy", {31'b0, busy},    32'd0);
    chk("rst_done", {31'b0, done},    32'd0);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].poke, lat);
      chk($sformatf("tbl%0d_latency", i), lat, LAT);
      chk($sformatf("tbl%0d_lo", i), {24'b0, s_multi}, {24'b0, tbl[i].lo});
      chk($sformatf("tbl%0d_ov", i), {31'b0, ov_mult}, {31'b0, tbl[i].ov});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_1cyc", i), {31'b0, done}, 32'd0);
      // An ignored mid-operation start must not spawn a second operation.
      repeat (3) begin
        @(posedge clk); #1;
        chk($sformatf("tbl%0d_no_extra", i), {30'b0, busy, done}, 32'd0);
      end
    end

    // Random operands against the arithmetic product
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_op(ra, rb, 1'b0, lat);
      check_result($sformatf("rnd%0d", k), lat, ra, rb);
    end

    // Start held high continuously: back-to-back operations every LAT+1 edges.
    @(negedge clk);
    A = 8'd3; B = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    A = 8'd7; B = 8'd9;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    chk("b2b_first_latency", lat, LAT);
    chk("b2b_first_lo", {24'b0, s_multi}, 32'd15);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) chk("b2b_busy_again", {31'b0, busy}, 32'd1);
      if (done) break;
    end
    start = 1'b0;
    chk("b2b_period", lat, LAT + 1);
    chk("b2b_second_lo", {24'b0, s_multi}, 32'd63);
    chk("b2b_second_ov", {31'b0, ov_mult}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle", {30'b0, busy, done}, 32'd0);

    // Reset in the middle of CALC: operation discarded, outputs cleared, no done.
    @(negedge clk);
    A = 8'd200; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy},    32'd0);
    chk("midrst_lo",   {24'b0, s_multi}, 32'd0);
    chk("midrst_ov",   {31'b0, ov_mult}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);

    // Operation after reset still works.
    run_op(8'd200, 8'd3, 1'b0, lat);
    check_result("post_rst", lat, 8'd200, 8'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
